router_in_arb: RTL and testbench

//  Packet-level round-robin arbiter sharing the 1x3 router's single input port between N_SRC upstream sources.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_rr_pick.sv | 43 ++++
 rtl/router_in_arb.sv | 153 +++++++++++++++
 tb/tb_router_in_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router input arbiter.
package router_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_WAIT_PV_ENC = 2'd1;
  localparam logic [1:0] ST_XFER_ENC    = 2'd2;
  localparam logic [1:0] ST_DRAIN_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_WAIT_PV = ST_WAIT_PV_ENC,
    ST_XFER    = ST_XFER_ENC,
    ST_DRAIN   = ST_DRAIN_ENC
  } arb_state_t;

  localparam int ROUTER_DATA_W = 8;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Rotating-priority picker: first requester at or above i_ptr (mod N_SRC).
// Purely combinational; no flow control of its own.
import router_pkg::*;

module router_rr_pick #(
  parameter int N_SRC = 3,
  parameter int PTR_W = ptr_w(N_SRC)
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_SRC-1:0] o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_SRC);

  logic [N_SRC-1:0] w_rot;
  logic [PTR_W-1:0] w_off;
  logic [PTR_W:0]   w_sum;

  // Bit k of w_rot is the request of source (i_ptr + k) mod N_SRC.
  assign w_rot = N_SRC'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_off = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PTR_W'(k);
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= N_EXT) ? PTR_W'(w_sum - N_EXT) : w_sum[PTR_W-1:0];
  assign o_any = |i_req;

  always_comb begin
    o_gnt = '0;
    for (int j = 0; j < N_SRC; j++) begin
      o_gnt[j] = o_any && (o_idx == PTR_W'(j));
    end
  end

endmodule

// File: rtl/router_in_arb.sv
// Packet-level round-robin arbiter in front of the router input; grant registered, data mux zero-latency.
// Router busy is forwarded combinationally as stall to the granted source only.
import router_pkg::*;

module router_in_arb #(
  parameter int N_SRC   = 3,
  parameter int DATA_W  = ROUTER_DATA_W,
  parameter int HDR_TMO = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_SRC-1:0]        src_req,
  input  logic [N_SRC-1:0]        src_pkt_valid,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_gnt,
  output logic [N_SRC-1:0]        src_stall,
  input  logic                    busy,
  output logic                    pkt_valid,
  output logic [DATA_W-1:0]       data_out,
  output logic                    tmo_err
);

  localparam int PTR_W = ptr_w(N_SRC);
  localparam int TMO_W = $clog2(HDR_TMO);

  arb_state_t       r_state;
  logic [N_SRC-1:0] r_gnt;
  logic [PTR_W-1:0] r_gidx;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  arb_state_t       w_state_nxt;
  logic [N_SRC-1:0] w_gnt_nxt;
  logic [PTR_W-1:0] w_gidx_nxt;
  logic [PTR_W-1:0] w_rr_ptr_nxt;
  logic [TMO_W-1:0] w_tmo_cnt_nxt;
  logic             w_tmo_err_nxt;

  logic [N_SRC-1:0]  w_pick_gnt;
  logic [PTR_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_active;
  logic              w_pv;
  logic              w_req_g;
  logic [DATA_W-1:0] w_data;
  logic [PTR_W-1:0]  w_gidx_inc;

  router_rr_pick #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req (src_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // One-hot select: r_gnt is all-zero outside a granted packet.
  always_comb begin
    w_pv   = 1'b0;
    w_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_gnt[i]) begin
        w_pv   = src_pkt_valid[i];
        w_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_active   = (r_state != ST_IDLE);
  assign w_req_g    = |(src_req & r_gnt);
  assign w_gidx_inc = (r_gidx == PTR_W'(N_SRC - 1)) ? '0 : r_gidx + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gidx    <= '0;
      r_rr_ptr  <= '0;
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gidx    <= w_gidx_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_tmo_err <= w_tmo_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gidx_nxt    = r_gidx;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_tmo_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // busy rising together with a request blocks the grant this cycle.
        if (w_pick_any && !busy) begin
          w_state_nxt   = ST_WAIT_PV;
          w_gnt_nxt     = w_pick_gnt;
          w_gidx_nxt    = w_pick_idx;
          w_tmo_cnt_nxt = '0;
        end
      end
      ST_WAIT_PV: begin
        // A header arriving on the timeout cycle still wins over the timeout.
        if (w_pv) begin
          w_state_nxt   = ST_XFER;
          w_tmo_cnt_nxt = '0;
        end else if (!w_req_g) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = '0;
          w_tmo_cnt_nxt = '0;
        end else if (r_tmo_cnt == TMO_W'(HDR_TMO - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = '0;
          w_tmo_cnt_nxt = '0;
          w_tmo_err_nxt = 1'b1;
          w_rr_ptr_nxt  = w_gidx_inc;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
      end
      ST_XFER: begin
        if (!w_pv) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!busy) begin
          w_state_nxt  = ST_IDLE;
          w_gnt_nxt    = '0;
          w_rr_ptr_nxt = w_gidx_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign src_gnt   = r_gnt;
  assign src_stall = r_gnt & {N_SRC{busy}};
  assign pkt_valid = w_active & w_pv;
  assign data_out  = w_active ? w_data : '0;
  assign tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_router_in_arb.sv
// Bench for router_in_arb: directed table and corner sequences plus random traffic vs a packet-level model.
module tb_router_in_arb;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    src_req;
  logic [N-1:0]    src_pkt_valid;
  logic [N*DW-1:0] src_data;
  logic            busy;
  logic [N-1:0]    src_gnt;
  logic [N-1:0]    src_stall;
  logic            pkt_valid;
  logic [DW-1:0]   data_out;
  logic            tmo_err;

  always #5 clk = ~clk;

  router_in_arb #(.N_SRC(N), .DATA_W(DW), .HDR_TMO(TMO)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .src_req       (src_req),
    .src_pkt_valid (src_pkt_valid),
    .src_data      (src_data),
    .src_gnt       (src_gnt),
    .src_stall     (src_stall),
    .busy          (busy),
    .pkt_valid     (pkt_valid),
    .data_out      (data_out),
    .tmo_err       (tmo_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
  endtask

  // Packet-level model: which source owns the port and how far its packet has got.
  int m_g, m_ptr, m_wait;
  bit m_seen, m_fell, m_tmo, m_new;

  task automatic model_reset();
    m_g = -1; m_ptr = 0; m_wait = 0;
    m_seen = 0; m_fell = 0; m_tmo = 0; m_new = 0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    m_tmo = 0;
    m_new = 0;
    if (!resetn) begin
      model_reset();
    end else if (m_g < 0) begin
      if (src_req != '0 && !busy) begin
        m_g = pick(src_req, m_ptr);
        m_wait = 0; m_seen = 0; m_fell = 0; m_new = 1;
      end
    end else if (!m_seen) begin
      if (src_pkt_valid[m_g]) m_seen = 1;
      else if (!src_req[m_g]) m_g = -1;
      else if (m_wait == TMO - 1) begin
        m_ptr = (m_g + 1) % N;
        m_g = -1;
        m_tmo = 1;
      end else m_wait++;
    end else if (!m_fell) begin
      if (!src_pkt_valid[m_g]) m_fell = 1;
    end else if (!busy) begin
      m_ptr = (m_g + 1) % N;
      m_g = -1;
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0]  eg, es;
    logic          epv;
    logic [DW-1:0] ed;
    eg = '0; es = '0; epv = 1'b0; ed = '0;
    if (m_g >= 0) begin
      eg[m_g] = 1'b1;
      es[m_g] = busy;
      epv = src_pkt_valid[m_g];
      ed = src_data[m_g*DW +: DW];
    end
    chk("gnt_onehot", 32'($onehot0(src_gnt)), 32'd1);
    chk("gnt", 32'(src_gnt), 32'(eg));
    chk("stall", 32'(src_stall), 32'(es));
    chk("pkt_valid", 32'(pkt_valid), 32'(epv));
    chk("data_out", 32'(data_out), 32'(ed));
    chk("tmo_err", 32'(tmo_err), 32'(m_tmo));
  endtask

  // Fresh data on every source and random valid on sources that do not own the port.
  task automatic noise();
    src_data = (N*DW)'($urandom);
    for (int i = 0; i < N; i++) begin
      if (i != m_g) src_pkt_valid[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    noise();
    #1;
    check_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Granted source sends len bytes, then parity with busy held two more cycles.
  task automatic send_pkt(input int g, input int len);
    for (int b = 0; b < len; b++) begin
      src_pkt_valid[g] = 1'b1;
      busy = (b == 1);
      tick();
      if (b == 1) chk("xfer_stall", 32'(src_stall), 32'(onehot(g)));
    end
    src_pkt_valid[g] = 1'b0;
    src_req[g] = 1'b0;
    busy = 1'b1;
    tick();
    tick();
    busy = 1'b0;
    for (int t = 0; t < 8 && src_gnt != '0; t++) tick();
    chk("drain_end", 32'(src_gnt), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         busy;
    logic [N-1:0] exp_gnt;
  } rr_vec_t;

  rr_vec_t tbl[10];

  int pw, plen, pc, last_g;
  bit pdrop;

  initial begin
    tbl[0] = '{3'b111, 1'b0, 3'b001};
    tbl[1] = '{3'b111, 1'b0, 3'b010};
    tbl[2] = '{3'b111, 1'b0, 3'b100};
    tbl[3] = '{3'b111, 1'b0, 3'b001};
    tbl[4] = '{3'b101, 1'b0, 3'b100};
    tbl[5] = '{3'b010, 1'b1, 3'b000};
    tbl[6] = '{3'b110, 1'b0, 3'b010};
    tbl[7] = '{3'b011, 1'b0, 3'b001};
    tbl[8] = '{3'b001, 1'b0, 3'b001};
    tbl[9] = '{3'b100, 1'b0, 3'b100};

    resetn = 1'b0; src_req = '0; src_pkt_valid = '0; src_data = '0; busy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(src_gnt), 32'd0);
    chk("rst_stall", 32'(src_stall), 32'd0);
    chk("rst_pv", 32'(pkt_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_tmo", 32'(tmo_err), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      src_req = tbl[i].req;
      busy = tbl[i].busy;
      tick();
      chk($sformatf("rr_row%0d", i), 32'(src_gnt), 32'(tbl[i].exp_gnt));
      if (tbl[i].exp_gnt != '0) send_pkt(idx_of(tbl[i].exp_gnt), 4);
    end

    // Header timeout on src2; src0 waits behind it.
    src_req = 3'b100; busy = 1'b0;
    tick();
    chk("tmo_gnt", 32'(src_gnt), 32'b100);
    src_pkt_valid[2] = 1'b0;
    src_req = 3'b101;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 15) begin
        chk("tmo_early", 32'(tmo_err), 32'd0);
        chk("tmo_hold", 32'(src_gnt), 32'b100);
      end
    end
    chk("tmo_pulse", 32'(tmo_err), 32'd1);
    chk("tmo_clr", 32'(src_gnt), 32'd0);
    tick();
    chk("tmo_next", 32'(src_gnt), 32'b001);
    chk("tmo_once", 32'(tmo_err), 32'd0);
    send_pkt(0, 3);
    src_req = '0;

    // Header arrives on the timeout cycle.
    src_req = 3'b010;
    tick();
    chk("race_gnt", 32'(src_gnt), 32'b010);
    src_pkt_valid[1] = 1'b0;
    for (int c = 1; c <= 15; c++) tick();
    src_pkt_valid[1] = 1'b1;
    tick();
    chk("race_tmo", 32'(tmo_err), 32'd0);
    chk("race_hold", 32'(src_gnt), 32'b010);
    send_pkt(1, 2);

    // Reset in the middle of a src1 packet.
    src_req = 3'b010;
    tick();
    chk("rst2_gnt_pre", 32'(src_gnt), 32'b010);
    src_pkt_valid[1] = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    chk("rst2_gnt", 32'(src_gnt), 32'd0);
    chk("rst2_pv", 32'(pkt_valid), 32'd0);
    chk("rst2_tmo", 32'(tmo_err), 32'd0);
    model_reset();
    src_req = '0;
    tick();
    tick();
    resetn = 1'b1;

    // Request withdrawn while waiting for the header.
    src_req = 3'b001;
    tick();
    chk("wd_gnt", 32'(src_gnt), 32'b001);
    src_pkt_valid[0] = 1'b0;
    tick();
    src_req = '0;
    tick();
    chk("wd_idle", 32'(src_gnt), 32'd0);
    chk("wd_tmo", 32'(tmo_err), 32'd0);
    src_req = 3'b111;
    tick();
    chk("wd_ptr", 32'(src_gnt), 32'b001);
    send_pkt(0, 2);

    // Random traffic.
    pw = 0; plen = 1; pc = 0; pdrop = 0; last_g = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_new) begin
        pw = $urandom_range(0, 19);
        plen = $urandom_range(1, 5);
        pdrop = ($urandom_range(0, 7) == 0);
        pc = 0;
      end
      if (m_g >= 0) begin
        if (pdrop && pc == pw) begin
          src_req[m_g] = 1'b0;
          src_pkt_valid[m_g] = 1'b0;
        end else begin
          src_pkt_valid[m_g] = (pc >= pw && pc < pw + plen);
        end
        pc++;
      end else if (last_g >= 0) begin
        src_req[last_g] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < N; i++) begin
        if (i != m_g && !src_req[i] && $urandom_range(0, 3) == 0) src_req[i] = 1'b1;
      end
      busy = ($urandom_range(0, 2) == 0);
      last_g = m_g;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
